// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, op-group field values and issue-buffer state encoding
package alu_pkg;
  localparam int OPWIDTH = 6;
  localparam logic [1:0] GRP_SHIFT = 2'b11;
  localparam logic [5:0] OP_ADD = 6'b00_0000;
  localparam logic [5:0] OP_SUB = 6'b00_0001;
  localparam logic [5:0] OP_AND = 6'b01_0000;
  localparam logic [5:0] OP_OR  = 6'b01_0001;
  localparam logic [5:0] OP_XOR = 6'b01_0010;
  localparam logic [5:0] OP_SLL = 6'b11_0000;
  localparam logic [5:0] OP_SRL = 6'b11_0001;
  localparam logic [5:0] OP_SRA = 6'b11_0010;
  localparam logic [5:0] OP_ROL = 6'b11_0011;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} ibuf_state_e;
endpackage

// File: rtl/alu_op_normalize.sv
// alu_op_normalize: detects bitshift ops and clamps the shift amount to log2(WORDSIZE) bits
module alu_op_normalize import alu_pkg::*; #(
  parameter int WORDSIZE = 64
) (
  input  logic [1:0]          i_grp,
  input  logic [WORDSIZE-1:0] i_b,
  output logic [WORDSIZE-1:0] o_b,
  output logic                o_is_shift
);
  localparam int SW = $clog2(WORDSIZE);
  assign o_is_shift = i_grp == GRP_SHIFT;
  assign o_b = o_is_shift ? {{(WORDSIZE-SW){1'b0}}, i_b[SW-1:0]} : i_b;
endmodule

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: two-entry skid buffer between decode and the ALU; in_ready comes
// straight from the state register so out_ready never reaches decode combinationally.
module alu_issue_buffer #(
  parameter int WORDSIZE = 64,
  parameter int OPWIDTH  = alu_pkg::OPWIDTH,
  parameter int TAGWIDTH = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] in_a,
  input  logic [WORDSIZE-1:0] in_b,
  input  logic [OPWIDTH-1:0]  in_op,
  input  logic [TAGWIDTH-1:0] in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_a,
  output logic [WORDSIZE-1:0] out_b,
  output logic [OPWIDTH-1:0]  out_op,
  output logic [TAGWIDTH-1:0] out_rd,
  output logic                out_is_shift
);
  import alu_pkg::*;
  localparam int DW = 2*WORDSIZE + OPWIDTH + TAGWIDTH + 1;
  ibuf_state_e r_state, w_state_nx;
  logic [DW-1:0] r_main, r_skid, w_in;
  logic [WORDSIZE-1:0] w_b_norm;
  logic w_is_shift, w_in_fire, w_out_fire, w_ld_main, w_ld_skid, w_skid_to_main;
  alu_op_normalize #(.WORDSIZE(WORDSIZE)) u_norm (
    .i_grp(in_op[5:4]),
    .i_b(in_b),
    .o_b(w_b_norm),
    .o_is_shift(w_is_shift)
  );
  assign w_in = {in_a, w_b_norm, in_op, in_rd, w_is_shift};
  assign in_ready = r_state != FULL;
  assign out_valid = r_state != EMPTY;
  assign {out_a, out_b, out_op, out_rd, out_is_shift} = r_main;
  assign w_in_fire = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  always_comb begin
    w_state_nx = r_state;
    w_ld_main = w_in_fire & !flush & (r_state == EMPTY | w_out_fire);
    w_ld_skid = w_in_fire & !flush & r_state == BUSY & !w_out_fire;
    w_skid_to_main = r_state == FULL & w_out_fire;
    if (flush) w_state_nx = EMPTY;
    else if (r_state == EMPTY) w_state_nx = w_in_fire ? BUSY : EMPTY;
    else if (r_state == BUSY) w_state_nx = w_in_fire ? (w_out_fire ? BUSY : FULL) : (w_out_fire ? EMPTY : BUSY);
    else w_state_nx = w_out_fire ? BUSY : FULL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= EMPTY;
    else r_state <= w_state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main) r_main <= w_in;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_ld_skid) r_skid <= w_in;
    end
endmodule

// File: tb/tb_alu_issue_buffer.sv
// tb_alu_issue_buffer: directed vectors with hand-computed expectations for alu_issue_buffer
module tb_alu_issue_buffer;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_is_shift;
  logic [63:0] in_a = 0, in_b = 0, out_a, out_b;
  logic [5:0] in_op = 0, out_op;
  logic [4:0] in_rd = 0, out_rd;
  int errors = 0, checks = 0;

  alu_issue_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
    .out_is_shift(out_is_shift)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_rd = rd;
  endtask

  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_b", out_b, 0);
    check("rst_out_rd", out_rd, 0);
    rst_n = 1;
    tick;
    // single shift op: amount 0x41 masks to 1
    out_ready = 1;
    drive(1, 6'b11_0011, 64'h1, 64'h41, 5'd7);
    tick;
    in_valid = 0;
    check("single_valid", out_valid, 1);
    check("single_b", out_b, 64'h1);
    check("single_shift", out_is_shift, 1);
    check("single_a", out_a, 64'h1);
    check("single_rd", out_rd, 7);
    tick;
    check("single_drain", out_valid, 0);
    // boundary: amount bits above bit 5 all set, low bits zero
    drive(1, 6'b11_0000, 64'h5, 64'hFFFF_FFFF_FFFF_FFC0, 5'd2);
    tick;
    in_valid = 0;
    check("mask_hi_b", out_b, 64'h0);
    drive(1, 6'b11_0010, 64'h5, 64'h3F, 5'd2);
    tick;
    in_valid = 0;
    check("mask_max_b", out_b, 64'h3F);
    tick;
    // back-to-back stream
    for (int i = 0; i < 8; i++) begin
      drive(1, 6'b00_0000, 64'(i * 3), 64'(i), 5'(i));
      tick;
      check("stream_ready", in_ready, 1);
      check("stream_valid", out_valid, 1);
      check("stream_rd", out_rd, 64'(i));
      check("stream_a", out_a, 64'(i * 3));
    end
    in_valid = 0;
    tick;
    check("stream_drain", out_valid, 0);
    // backpressure: two ops stall, third held at input is refused
    out_ready = 0;
    drive(1, 6'b00_0001, 64'hA3, 64'h1, 5'd3);
    tick;
    check("bp_busy_ready", in_ready, 1);
    drive(1, 6'b00_0001, 64'hA4, 64'h2, 5'd4);
    tick;
    check("bp_full_ready", in_ready, 0);
    check("bp_full_rd", out_rd, 3);
    drive(1, 6'b00_0001, 64'hA5, 64'h3, 5'd5);
    tick;
    check("bp_hold_rd", out_rd, 3);
    check("bp_hold_a", out_a, 64'hA3);
    check("bp_hold_ready", in_ready, 0);
    in_valid = 0;
    out_ready = 1;
    #1;
    check("bp_first_rd", out_rd, 3);
    tick;
    check("bp_second_rd", out_rd, 4);
    check("bp_second_a", out_a, 64'hA4);
    check("bp_ready_back", in_ready, 1);
    tick;
    check("bp_drain", out_valid, 0);
    // non-shift op keeps b unchanged
    drive(1, 6'b00_0001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
    tick;
    in_valid = 0;
    check("ns_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
    check("ns_shift", out_is_shift, 0);
    tick;
    // flush in FULL with in_valid high
    out_ready = 0;
    drive(1, 6'b00_0000, 64'h10, 64'h0, 5'd10);
    tick;
    drive(1, 6'b00_0000, 64'h11, 64'h0, 5'd11);
    tick;
    check("fl_full", in_ready, 0);
    drive(1, 6'b00_0000, 64'h12, 64'h0, 5'd12);
    flush = 1;
    tick;
    flush = 0;
    in_valid = 0;
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    out_ready = 1;
    tick;
    check("fl_no_ghost", out_valid, 0);
    // flush in BUSY overrides a simultaneous capture
    out_ready = 0;
    drive(1, 6'b00_0000, 64'h20, 64'h0, 5'd13);
    tick;
    drive(1, 6'b00_0000, 64'h21, 64'h0, 5'd14);
    flush = 1;
    tick;
    flush = 0;
    in_valid = 0;
    check("fl_busy_valid", out_valid, 0);
    check("fl_busy_ready", in_ready, 1);
    // asynchronous reset mid-cycle while FULL
    drive(1, 6'b00_0000, 64'h30, 64'h0, 5'd20);
    tick;
    drive(1, 6'b00_0000, 64'h31, 64'h0, 5'd21);
    tick;
    in_valid = 0;
    check("ar_full", in_ready, 0);
    #2 rst_n = 0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready, 1);
    check("ar_rd", out_rd, 0);
    #1 rst_n = 1;
    tick;
    check("ar_after_valid", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_buffer.md
Name: alu_issue_buffer

Overview:
- Two-entry skid buffer between the decode stage and the ALU function units, including the bitshift unit. Registers operands, the 6-bit ALU operation and the destination tag, and presents them to the ALU with a valid/ready handshake.
- Breaks the combinational ready path from the ALU and writeback back into decode.
- At capture, masks the shift amount of bitshift operations (op[5:4] = 2'b11) to log2(WORDSIZE) bits, so the shifter never sees an out-of-range amount.

Parameters:
- WORDSIZE, 64, operand width in bits.
- OPWIDTH, 6, ALU operation code width.
- TAGWIDTH, 5, destination register tag width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  discard all buffered operations (branch mispredict or trap).
- in_valid  input  1  decode presents an operation.
- in_ready  output  1  buffer can accept; registered signal.
- in_a  input  WORDSIZE  first operand.
- in_b  input  WORDSIZE  second operand or shift amount.
- in_op  input  OPWIDTH  ALU operation code.
- in_rd  input  TAGWIDTH  destination tag.
- out_valid  output  1  ALU operation available.
- out_ready  input  1  ALU/writeback consumes the operation.
- out_a  output  WORDSIZE  registered first operand.
- out_b  output  WORDSIZE  registered, normalised second operand.
- out_op  output  OPWIDTH  registered operation.
- out_rd  output  TAGWIDTH  registered tag.
- out_is_shift  output  1  out_op[5:4] == 2'b11.

Behaviour:
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives the out_* ports) and skid register, each with a valid bit.
- Reset (rst_n low, asynchronous):
  - both valid bits 0, all data registers 0.
  - out_valid = 0, in_ready = 1, out_* = 0.
- States (derived from the valid bits):
  - EMPTY (main 0, skid 0).
  - BUSY (main 1, skid 0).
  - FULL (main 1, skid 1).
- EMPTY: in_fire -> BUSY, main <= input.
- BUSY transitions:
  - in_fire & out_fire -> BUSY, main <= input.
  - in_fire & !out_fire -> FULL, skid <= input.
  - !in_fire & out_fire -> EMPTY.
  - neither -> hold.
- FULL transitions:
  - in_ready is 0, so no capture.
  - out_fire -> BUSY, main <= skid.
  - otherwise hold.
- in_ready = !skid_valid, taken from a register. It never depends combinationally on out_ready.
- Latency and throughput: 1 cycle from in_fire to out_valid; sustained throughput 1 op/cycle while out_ready stays high.
- Output stability: while out_valid & !out_ready, all out_* hold their values bit-for-bit.
- Shift normalisation at capture:
  - if in_op[5:4] == 2'b11, stored b = {zeros, in_b[$clog2(WORDSIZE)-1:0]}.
  - otherwise stored b = in_b unchanged.
  - out_is_shift is computed at capture and stored.
- Unknown op codes pass through unmodified; legality checks belong to decode.
- Flush:
  - on the edge with flush = 1, both valid bits clear. The next cycle out_valid = 0 and in_ready = 1.
  - flush overrides a simultaneous in_fire; the incoming op is dropped.
  - an out_fire in the same cycle is still a legal consumption by the ALU.
- Data registers need no reset for function, but they are reset to 0 for deterministic waveforms.
- Reset asserted mid-operation: immediate return to EMPTY, buffered ops lost.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU op-code localparams, including the bitshift group 6'b11_0000 to 6'b11_0011 and the group-select field [5:4] = 2'b11.
  - OPWIDTH.
  - the issue-buffer state encoding (EMPTY/BUSY/FULL).
- Optional combinational sub-module alu_op_normalize performs the shift-amount masking and is_shift detection, so the ALU testbench can reuse it.

Test Plan:
- Reset then single op: in_op = 6'b11_0011, in_a = 1, in_b = 64'h41, out_ready = 1 -> next cycle out_valid = 1, out_b = 64'h1, out_is_shift = 1; the cycle after, out_valid = 0.
- Back-to-back stream: 8 ops on consecutive cycles, out_ready = 1 -> 8 outputs on consecutive cycles, in order, in_ready stays 1.
- Backpressure: out_ready = 0, in_valid held, two ops (tags 3 then 4) issued -> after the second capture in_ready = 0 and out_rd = 3 stays stable. Then out_ready = 1 -> out_rd = 3, then 4, and in_ready returns to 1.
- Non-shift op: in_op = 6'b00_0001, in_b = 64'hFFFF_FFFF_FFFF_FFFF -> out_b unchanged, out_is_shift = 0.
- Flush in FULL with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1; the dropped op never appears on the outputs.
- Asynchronous reset pulsed mid-cycle while FULL -> out_valid = 0 and in_ready = 1 immediately, before the next clock edge.
